// File: rtl/jtag_shift_serdes_pkg.sv
// Shared JTAG definitions for the shift serdes slice.
// Provides the project-wide default data word width.
package jtag_shift_serdes_pkg;

  localparam int unsigned JTAG_WORD_W = 32;

endpackage : jtag_shift_serdes_pkg

// File: rtl/jtag_bit_packer.sv
// RX side: packs TDO bits LSB-first into words, with an output slot,
// flush of partial words and back-pressure toward the TAP.
module jtag_bit_packer
  import jtag_shift_serdes_pkg::*;
#(
  parameter int unsigned WORD_W = JTAG_WORD_W,
  parameter int unsigned CNT_W  = $clog2(WORD_W) + 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              bit_i,
  input  logic              bit_wr_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] data_o,
  output logic [CNT_W-1:0]  bits_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              overrun_o
);

  localparam logic [CNT_W-1:0] FULL   = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ALMOST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [WORD_W-1:0] acc_word_q, acc_word_d, data_q, data_d, bit_vec_s;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, bits_q, bits_d;
  logic              flush_pend_q, flush_pend_d, valid_q, valid_d;
  logic              overrun_q, overrun_d, emit_s;

  assign bit_vec_s = {{(WORD_W-1){1'b0}}, bit_i};

  // Next-state for accumulator, output slot and overrun flag.
  always_comb begin
    acc_word_d   = acc_word_q;
    acc_cnt_d    = acc_cnt_q;
    flush_pend_d = flush_pend_q;
    data_d       = data_q;
    bits_d       = bits_q;
    valid_d      = valid_q;
    emit_s       = ((acc_cnt_q == FULL) || (flush_pend_q && (acc_cnt_q != ZERO)))
                   && (!valid_q || ready_i);
    overrun_d    = overrun_q || (bit_wr_i && !emit_s && (acc_cnt_q == FULL));

    if (emit_s) begin
      data_d  = acc_word_q;
      bits_d  = acc_cnt_q;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // A bit landing on the move edge seeds the fresh accumulator.
    if (emit_s) begin
      acc_word_d   = bit_wr_i ? bit_vec_s : {WORD_W{1'b0}};
      acc_cnt_d    = bit_wr_i ? ONE : ZERO;
      flush_pend_d = flush_i && bit_wr_i;
    end else begin
      if (bit_wr_i && (acc_cnt_q != FULL)) begin
        acc_word_d = acc_word_q | (bit_vec_s << acc_cnt_q);
        acc_cnt_d  = acc_cnt_q + ONE;
      end else begin
        acc_word_d = acc_word_q;
        acc_cnt_d  = acc_cnt_q;
      end
      flush_pend_d = (flush_pend_q || flush_i) && ((acc_cnt_q != ZERO) || bit_wr_i);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_word_q   <= {WORD_W{1'b0}};
      acc_cnt_q    <= ZERO;
      flush_pend_q <= 1'b0;
      data_q       <= {WORD_W{1'b0}};
      bits_q       <= ZERO;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      acc_word_q   <= acc_word_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      bits_q       <= bits_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign bits_o    = bits_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign last_o    = ((acc_cnt_q == ALMOST) && valid_q) || (acc_cnt_q == FULL);

endmodule : jtag_bit_packer

// File: rtl/rstn_sync.sv
// Reset synchronizer: asserts asynchronously, releases two clocks after rstn_i rises.
module rstn_sync (
  input  logic clk_i,
  input  logic rstn_i,
  output logic rstn_o
);

  logic [1:0] sync_q;

  // Two-stage shift toward release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rstn_o = sync_q[1];

endmodule : rstn_sync

// File: rtl/jtag_shift_serdes.sv
// Bit-stream adapter between the word data path and the TAP shift interface:
// TX serializer (cur/nxt double buffer) plus RX packer.
module jtag_shift_serdes
  import jtag_shift_serdes_pkg::*;
#(
  parameter int unsigned WORD_W = JTAG_WORD_W,
  parameter int unsigned CNT_W  = $clog2(WORD_W) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] tx_data,
  input  logic [CNT_W-1:0]  tx_bits,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              shift_in,
  input  logic              shift_in_rd,
  output logic              shift_in_last,
  output logic [WORD_W-1:0] rx_data,
  output logic [CNT_W-1:0]  rx_bits,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              shift_out,
  input  logic              shift_out_wr,
  output logic              shift_out_last,
  input  logic              rx_flush,
  output logic              tx_empty,
  output logic              err_underrun,
  output logic              err_overrun
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic              rst_n_s;
  logic [WORD_W-1:0] cur_word_q, cur_word_d, nxt_word_q, nxt_word_d;
  logic [CNT_W-1:0]  cur_left_q, cur_left_d, nxt_left_q, nxt_left_d, tx_len_s;
  logic              nxt_valid_q, nxt_valid_d, underrun_q, underrun_d;
  logic              accept_s, xfer_s;

  rstn_sync u_rstn_sync (
    .clk_i  (clk),
    .rstn_i (rstn),
    .rstn_o (rst_n_s)
  );

  // TX next-state: accept into nxt, seamless nxt->cur handoff, shift on read.
  always_comb begin
    cur_word_d  = cur_word_q;
    cur_left_d  = cur_left_q;
    nxt_word_d  = nxt_word_q;
    nxt_left_d  = nxt_left_q;
    nxt_valid_d = nxt_valid_q;
    accept_s    = tx_valid && tx_ready;
    xfer_s      = nxt_valid_q && ((cur_left_q == ZERO) || ((cur_left_q == ONE) && shift_in_rd));
    underrun_d  = underrun_q || (shift_in_rd && (cur_left_q == ZERO));

    if ((tx_bits == ZERO) || (tx_bits > FULL)) begin
      tx_len_s = FULL;
    end else begin
      tx_len_s = tx_bits;
    end

    if (xfer_s) begin
      cur_word_d = nxt_word_q;
      cur_left_d = nxt_left_q;
    end else if (shift_in_rd && (cur_left_q != ZERO)) begin
      cur_word_d = cur_word_q >> 1;
      cur_left_d = cur_left_q - ONE;
    end else begin
      cur_word_d = cur_word_q;
      cur_left_d = cur_left_q;
    end

    if (accept_s) begin
      nxt_word_d  = tx_data;
      nxt_left_d  = tx_len_s;
      nxt_valid_d = 1'b1;
    end else if (xfer_s) begin
      nxt_valid_d = 1'b0;
    end else begin
      nxt_valid_d = nxt_valid_q;
    end
  end

  // TX state registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      cur_word_q  <= {WORD_W{1'b0}};
      cur_left_q  <= ZERO;
      nxt_word_q  <= {WORD_W{1'b0}};
      nxt_left_q  <= ZERO;
      nxt_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cur_word_q  <= cur_word_d;
      cur_left_q  <= cur_left_d;
      nxt_word_q  <= nxt_word_d;
      nxt_left_q  <= nxt_left_d;
      nxt_valid_q <= nxt_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  // tx_ready stays low until the synchronized reset has released.
  assign tx_ready      = rst_n_s && !nxt_valid_q;
  assign shift_in      = (cur_left_q != ZERO) ? cur_word_q[0] : 1'b0;
  assign shift_in_last = (cur_left_q <= ONE) && !nxt_valid_q;
  assign tx_empty      = (cur_left_q == ZERO) && !nxt_valid_q;
  assign err_underrun  = underrun_q;

  jtag_bit_packer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_packer (
    .clk_i     (clk),
    .rstn_i    (rst_n_s),
    .bit_i     (shift_out),
    .bit_wr_i  (shift_out_wr),
    .flush_i   (rx_flush),
    .data_o    (rx_data),
    .bits_o    (rx_bits),
    .valid_o   (rx_valid),
    .ready_i   (rx_ready),
    .last_o    (shift_out_last),
    .overrun_o (err_overrun)
  );

endmodule : jtag_shift_serdes

// File: tb/tb_jtag_shift_serdes.sv
// Directed bench for jtag_shift_serdes: TX seamless/underrun, RX full word,
// back-pressure/overrun, flush and mid-stream reset.
module tb_jtag_shift_serdes;

  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic [W-1:0]  tx_data;
  logic [CW-1:0] tx_bits;
  logic          tx_valid, tx_ready, shift_in, shift_in_rd, shift_in_last;
  logic [W-1:0]  rx_data;
  logic [CW-1:0] rx_bits;
  logic          rx_valid, rx_ready, shift_out, shift_out_wr, shift_out_last;
  logic          rx_flush, tx_empty, err_underrun, err_overrun;

  int n_vec  = 0;
  int n_miss = 0;

  jtag_shift_serdes #(.WORD_W(W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .tx_data        (tx_data),
    .tx_bits        (tx_bits),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .shift_in       (shift_in),
    .shift_in_rd    (shift_in_rd),
    .shift_in_last  (shift_in_last),
    .rx_data        (rx_data),
    .rx_bits        (rx_bits),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .shift_out      (shift_out),
    .shift_out_wr   (shift_out_wr),
    .shift_out_last (shift_out_last),
    .rx_flush       (rx_flush),
    .tx_empty       (tx_empty),
    .err_underrun   (err_underrun),
    .err_overrun    (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " tx_ready"}, tx_ready, 0);
    chk({tag, " shift_in"}, shift_in, 0);
    chk({tag, " shift_in_last"}, shift_in_last, 1);
    chk({tag, " tx_empty"}, tx_empty, 1);
    chk({tag, " rx_valid"}, rx_valid, 0);
    chk({tag, " rx_data"}, rx_data, 0);
    chk({tag, " rx_bits"}, rx_bits, 0);
    chk({tag, " shift_out_last"}, shift_out_last, 0);
    chk({tag, " err_underrun"}, err_underrun, 0);
    chk({tag, " err_overrun"}, err_overrun, 0);
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic [CW-1:0] b);
    tx_data  = d;
    tx_bits  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 20 && !tx_ready; i++) tick();
    chk("tx_ready wait", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic write_bit(input logic v);
    shift_out    = v;
    shift_out_wr = 1'b1;
    tick();
    shift_out_wr = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    for (int i = 0; i < 8 && !rx_valid; i++) tick();
    chk(tag, rx_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] seam;
    logic [63:0] pat;
    logic        seen;

    rstn = 1'b0; tx_data = '0; tx_bits = '0; tx_valid = 1'b0; shift_in_rd = 1'b0;
    rx_ready = 1'b0; shift_out = 1'b0; shift_out_wr = 1'b0; rx_flush = 1'b0;
    #12;
    check_reset_outputs("rst");
    tick();
    rstn = 1'b1;
    tick(); tick(); tick();
    chk("post-reset tx_ready", tx_ready, 1);

    // TX seamless: 32 + 2 bits with read held high
    seam = {2'b11, 32'hA5A5_A5A5};
    send_word(32'hA5A5_A5A5, 6'd32);
    send_word(32'h0000_0003, 6'd2);
    shift_in_rd = 1'b1;
    for (int k = 0; k < 34; k++) begin
      chk("tx_seam bit", shift_in, seam[k]);
      chk("tx_seam last", shift_in_last, (k == 33) ? 1 : 0);
      tick();
    end
    shift_in_rd = 1'b0;
    chk("tx_seam empty", tx_empty, 1);
    chk("tx_seam no underrun", err_underrun, 0);

    // TX partial word then underrun
    send_word(32'h0000_0005, 6'd3);
    tick();
    shift_in_rd = 1'b1;
    chk("tx_part b0", shift_in, 1);
    chk("tx_part last0", shift_in_last, 0);
    tick();
    chk("tx_part b1", shift_in, 0);
    tick();
    chk("tx_part b2", shift_in, 1);
    chk("tx_part last2", shift_in_last, 1);
    tick();
    chk("tx_under shift_in", shift_in, 0);
    chk("tx_under pre", err_underrun, 0);
    tick();
    shift_in_rd = 1'b0;
    chk("tx_under set", err_underrun, 1);
    tick();
    chk("tx_under sticky", err_underrun, 1);

    // RX full word, alternating 1/0
    rx_ready = 1'b1;
    for (int k = 0; k < 32; k++) write_bit((k % 2) == 0);
    wait_rx("rx_full valid");
    chk("rx_full data", rx_data, 32'h5555_5555);
    chk("rx_full bits", rx_bits, 32);
    tick();
    chk("rx_full one cycle", rx_valid, 0);

    // RX back-pressure and overrun
    rx_ready = 1'b0;
    pat = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 63; k++) write_bit(pat[k]);
    chk("rx_bp last", shift_out_last, 1);
    chk("rx_bp slot full", rx_valid, 1);
    chk("rx_bp no overrun", err_overrun, 0);
    write_bit(pat[63]);
    chk("rx_bp 64th ok", err_overrun, 0);
    write_bit(1'b1);
    chk("rx_bp overrun", err_overrun, 1);
    rx_ready = 1'b1;
    chk("rx_bp w1 data", rx_data, 32'h89AB_CDEF);
    chk("rx_bp w1 bits", rx_bits, 32);
    tick();
    chk("rx_bp w2 valid", rx_valid, 1);
    chk("rx_bp w2 data", rx_data, 32'h0123_4567);
    tick();
    chk("rx_bp drained", rx_valid, 0);
    chk("rx_bp last clr", shift_out_last, 0);

    // RX flush of partial word
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    rx_flush = 1'b1;
    tick();
    rx_flush = 1'b0;
    wait_rx("rx_flush valid");
    chk("rx_flush data", rx_data, 32'h0000_000B);
    chk("rx_flush bits", rx_bits, 5);
    tick();
    chk("rx_flush one cycle", rx_valid, 0);
    rx_flush = 1'b1;
    tick();
    rx_flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= rx_valid;
      tick();
    end
    chk("rx_flush empty noop", seen, 0);

    // write and flush on the same edge: the bit goes out with the flush
    shift_out = 1'b1; shift_out_wr = 1'b1; rx_flush = 1'b1;
    tick();
    shift_out_wr = 1'b0; rx_flush = 1'b0;
    wait_rx("rx_wrflush valid");
    chk("rx_wrflush data", rx_data, 32'h0000_0001);
    chk("rx_wrflush bits", rx_bits, 1);
    tick();

    // Reset mid-stream in both directions
    send_word(32'h0000_FFFF, 6'd16);
    send_word(32'h0000_00FF, 6'd8);
    shift_in_rd = 1'b1;
    tick(); tick(); tick();
    shift_in_rd = 1'b0;
    rx_ready = 1'b0;
    for (int k = 0; k < 10; k++) write_bit(1'b1);
    chk("mid tx busy", tx_empty, 0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid");
    tick();
    rstn = 1'b1;
    rx_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= rx_valid;
      tick();
    end
    chk("mid no rx_valid", seen, 0);
    chk("mid tx_ready", tx_ready, 1);
    chk("mid tx_empty", tx_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_jtag_shift_serdes

// File: doc/jtag_shift_serdes.md
Name: jtag_shift_serdes

Overview:
- Bit-stream adapter between the word-wide data path and the TAP controller's shift interface.
- Serializer path: accepts WORD_W-bit words (LSB first, with a valid-bit count) and drives shift_in / shift_in_last, advancing on shift_in_rd.
- Deserializer path: packs shift_out bits (strobed by shift_out_wr) into words, drives shift_out_last for back-pressure, and emits words with a bit count.
- Sits directly upstream (TX) and downstream (RX) of the TAP controller, and is clocked on the same clk as that controller.

Parameters:
WORD_W, 32, data word width in bits; must be ≥2.
CNT_W, $clog2(WORD_W)+1, width of bit-count fields; holds 0..WORD_W.

Ports:
clk  in  1  system clock, same clock as TCK source
rstn  in  1  asynchronous active-low reset; deassertion synchronized internally
tx_data  in  WORD_W  word to serialize, bit 0 shifted first
tx_bits  in  CNT_W  valid bits in tx_data, 1..WORD_W; 0 is treated as WORD_W
tx_valid  in  1  tx word valid
tx_ready  out  1  tx word accepted when tx_valid&&tx_ready
shift_in  out  1  current TDI bit to TAP
shift_in_rd  in  1  TAP consumes shift_in at this posedge
shift_in_last  out  1  current bit is the last one buffered
rx_data  out  WORD_W  packed TDO word, first bit in bit 0
rx_bits  out  CNT_W  valid bits in rx_data
rx_valid  out  1  rx word valid
rx_ready  in  1  rx word taken when rx_valid&&rx_ready
shift_out  in  1  TDO bit from TAP
shift_out_wr  in  1  shift_out valid at this posedge
shift_out_last  out  1  at most one more bit can be stored
rx_flush  in  1  single-cycle pulse: emit the partial word
tx_empty  out  1  no bits buffered on the TX side
err_underrun  out  1  sticky: shift_in_rd seen with no bit buffered
err_overrun  out  1  sticky: shift_out_wr seen with no space

Behaviour:
Reset and handshake:
- All registers clear asynchronously. Outputs at reset: tx_ready=0 while reset is asserted, then 1; shift_in=0, shift_in_last=1, tx_empty=1, rx_valid=0, rx_data=0, rx_bits=0, shift_out_last=0, err_*=0.
- A reset mid-operation discards all buffered bits with no partial emission.
- tx_valid/tx_ready and rx_valid/rx_ready follow valid/ready rules: a held valid must not drop and data must not change until accepted.

TX path:
- Registers: cur_word, cur_left (0..WORD_W), nxt_word, nxt_left, nxt_valid.
- tx_ready = !nxt_valid. An accepted word goes into the nxt slot.
- nxt→cur transfer happens when cur_left==0, or when cur_left==1 && shift_in_rd (seamless, no bubble). Latency from acceptance into an empty block to shift_in valid: 2 cycles.
- A transfer and a new tx acceptance in the same cycle are both honoured.
- shift_in = cur_left ? cur_word[0] : 0.
- On shift_in_rd with cur_left>0: cur_word>>1, cur_left-1.
- On shift_in_rd with cur_left==0: no state change, set err_underrun.
- shift_in_last = (cur_left≤1) && !nxt_valid, combinational, re-evaluated every cycle.
- tx_empty = (cur_left==0) && !nxt_valid.

RX path:
- Registers: acc_word, acc_cnt (0..WORD_W), output slot rx_data/rx_bits/rx_valid, flush_pend.
- On shift_out_wr with acc_cnt<WORD_W: acc_word[acc_cnt]=shift_out, acc_cnt+1.
- Word emission: when acc_cnt==WORD_W, or flush_pend with acc_cnt>0, and the slot is free or freeing this cycle (rx_valid&&rx_ready), move acc to the slot with rx_bits=acc_cnt, and clear acc_word, acc_cnt and flush_pend.
- A bit written on the same edge as a move starts the new accumulator at acc_cnt=1.
- rx_flush sets flush_pend. With acc_cnt==0 and no write in that cycle, flush is a no-op and flush_pend clears.
- If a write and rx_flush occur in the same cycle, the bit is included before the flush.
- shift_out_last = (acc_cnt==WORD_W-1 && rx_valid) || acc_cnt==WORD_W. This lets the TAP store the current bit and then pause.
- shift_out_wr with acc_cnt==WORD_W still pending: bit dropped, set err_overrun.

General:
- All counters are saturating and unsigned; no wrap-around is permitted.
- The TX and RX paths are independent and may operate in the same cycle.

Decomposition:
- Shared JTAG include (alongside the existing command defines): no new typedefs. Add JTAG_WORD_W as the project-wide default for WORD_W.
- Reuse the existing rstn_sync cell for reset deassertion.
- One natural sub-module: jtag_bit_packer (the RX accumulator plus output slot), so the TX and RX paths can be verified separately.

Test Plan:
- TX seamless: two words, 0xA5A5A5A5 (bits=32) then 0x3 (bits=2), with shift_in_rd held high → 34 consecutive bits, LSB first, no gap. shift_in_last rises only on the 34th bit; tx_empty=1 afterwards.
- TX partial/underrun: word 0x5, bits=3; read 3 bits → 1,0,1 with shift_in_last=1 on bit 3. A 4th shift_in_rd → shift_in=0 and err_underrun=1 (sticky).
- RX full word: 32 writes of alternating 1/0 with rx_ready=1 → rx_valid for one cycle with rx_data=0x55555555, rx_bits=32.
- RX back-pressure: rx_ready=0, write 63 bits → shift_out_last=1 after the 63rd bit (acc_cnt=31, slot full). The 64th bit is accepted; a 65th bit sets err_overrun. Releasing rx_ready drains two words.
- RX flush: write 5 bits 1,1,0,1,0, then pulse rx_flush → rx_data=0x0B, rx_bits=5. A flush with an empty accumulator produces no rx_valid.
- Reset mid-stream: assert rstn low while a half-shifted word is pending in both directions → all outputs return to reset values next cycle; no rx_valid after release.
